// File: rtl/traffic_source.sv
// Synthetic NoC flit generator: an LFSR-paced injector feeds a small FIFO that drains
// onto a registered req/data link, with drop and 1024-cycle throughput accounting.
module traffic_source #(
    parameter int          SIZE   = 8,
    parameter int          QDEPTH = 4,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      rate,
    input  logic            busy,
    output logic            req,
    output logic [SIZE-1:0] data,
    output logic [25:0]     throughput,
    output logic [15:0]     dropped,
    output logic [3:0]      backlog
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [3:0]  QD       = 4'(QDEPTH);
    localparam logic [3:0]  QLAST    = 4'(QDEPTH - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        return (p == QLAST) ? 4'd0 : p + 4'd1;
    endfunction

    logic [15:0]     lfsr_q, lfsr_d;
    logic [SIZE-1:0] seq_q;
    logic [3:0]      wptr_q, rptr_q, count_q, count_d;
    logic [SIZE-1:0] mem_q [0:15];
    logic            req_q;
    logic [SIZE-1:0] data_q;
    logic [15:0]     dropped_q;
    logic [9:0]      sampler_q;
    logic [25:0]     running_q, throughput_q;
    logic            gen, push, pop;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        gen    = enable & ((rate == 8'hFF) | (lfsr_q[7:0] < rate));
        pop    = (count_q != 4'd0) & ~busy;
        // A full queue still accepts a flit when the head leaves in the same cycle.
        push   = gen & ((count_q < QD) | pop);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= seq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= SEED_EFF;
            seq_q        <= '0;
            wptr_q       <= 4'd0;
            rptr_q       <= 4'd0;
            count_q      <= 4'd0;
            req_q        <= 1'b0;
            data_q       <= '0;
            dropped_q    <= 16'd0;
            sampler_q    <= 10'd0;
            running_q    <= 26'd0;
            throughput_q <= 26'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            req_q   <= pop;
            if (gen) begin
                seq_q <= seq_q + 1'b1;
            end
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
                data_q <= mem_q[rptr_q];
            end
            if (gen & ~push) begin
                dropped_q <= sat_inc16(dropped_q);
            end
            // The closing window includes the flit on the link during its last cycle.
            if (sampler_q == 10'd1023) begin
                throughput_q <= running_q + {25'd0, req_q};
                running_q    <= 26'd0;
                sampler_q    <= 10'd0;
            end else begin
                running_q <= running_q + {25'd0, req_q};
                sampler_q <= sampler_q + 10'd1;
            end
        end
    end

    assign req        = req_q;
    assign data       = data_q;
    assign throughput = throughput_q;
    assign dropped    = dropped_q;
    assign backlog    = count_q;

endmodule

// File: doc/traffic_source.md
# traffic_source

Synthetic flit generator for the transmit end of a NoC link; the counterpart of the flit sink on the far side of the link. It injects flits at a programmable pseudo-random rate, buffers them in a small queue, and presents them on a `req`/`data`/`busy` interface consumed by the serial transmitter. Payloads carry a wrapping sequence number so the receiving end can detect loss and reordering. A per-1024-cycle injection throughput counter mirrors the sink's measurement for end-to-end comparison.

## Interface
- `SIZE`, 8: flit width in bits; set to the global flit size.
- `QDEPTH`, 4: queue depth in flits, 1..15.
- `SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: permits generation of new flits; draining continues when low.
- `rate` input 8: injection threshold, in 1/256 of a flit per cycle; 255 means every cycle.
- `busy` input 1: transmitter cannot accept a flit; registered by the consumer.
- `req` output 1: flit valid this cycle; registered.
- `data` output SIZE: flit payload, meaningful when `req`=1; registered.
- `throughput` output 26: flits issued in the last completed 1024-cycle window.
- `dropped` output 16: count of flits generated while the queue was full; saturates at 16'hFFFF.
- `backlog` output 4: current queue occupancy, 0..QDEPTH.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR shifts left every non-reset cycle, whether or not `enable` is high. The feedback bit is `l[15]^l[13]^l[12]^l[10]`, entering at bit 0.
- **Generation:** `gen` = `enable` & (`rate`==255 | `lfsr[7:0]` < `rate`), using the current (pre-shift) LFSR value.
  - `rate`=0 never generates.
- **Sequence counter:** `seq` (SIZE bits) increments on every `gen`, including dropped flits, and wraps from 2^SIZE−1 to 0. The generated payload is the pre-increment `seq`.
- **Queue:** FIFO with QDEPTH entries; circular read/write pointers plus a count.
  - `push` = `gen` & (count < QDEPTH | `pop`).
  - If `gen` arrives while full and there is no `pop`, the flit is dropped and `dropped` increments, saturating.
  - Simultaneous `push` and `pop` when full: both happen; count is unchanged.
  - Simultaneous `push` and `pop` when empty: not possible, because `pop` requires count>0 before the edge.
- **Issue:** `pop` = (count>0) & !`busy`.
  - On `pop`, the next edge sets `req`<=1 and `data`<=head.
  - Otherwise, `req`<=0 and `data` holds its value.
  - At most one flit is issued per cycle. Each cycle with `req`=1 is exactly one transferred flit; there is no retry and no hold.
- **Throughput:** 10-bit `sampler` and 26-bit `running` count.
  - Each cycle, `sampler` increments and `running` += `req`.
  - When `sampler`==1023: `throughput` <= `running` + `req`, `running` <= 0, and `sampler` <= 0. No flit is lost at the window boundary.
- `backlog` = count.

## Timing
- **Reset values:**
  - `req`=0, `data`=0, `throughput`=0, `dropped`=0, `backlog`=0.
  - `lfsr`=SEED, `seq`=0, `sampler`=0, `running`=0, and both pointers are 0.
- **Reset mid-operation:** the queue is flushed without issue, and `req` is low in the cycle after the reset edge. Pending flits are lost and not counted in `dropped`.
- **Latency:** with `gen` in cycle n, the push happens at the end of cycle n. With `busy`=0 in cycle n+1, `req`=1 is visible in cycle n+2.
- **Backpressure:** `busy`=1 in cycle k means no flit is issued in cycle k+1. Flits already issued are never withdrawn.
- **Sustained rate:** with `rate`=255 and `busy`=0, `req` stays high every cycle from cycle 2 on, and `backlog` stays at 1.
- **Enable:** `enable` deasserting stops generation at that cycle's edge; the queue then drains at one flit per non-busy cycle.

## Test plan
- **Reset:** reset for 3 cycles, then `enable`=0 → all outputs 0 for 2000 cycles, `throughput`=0 after the first window.
- **Full rate:** `rate`=255, `busy`=0, `enable`=1 →
  - `data` sequence 0,1,2,… with first `req` in cycle 2 after reset release;
  - `data` wraps 255→0 for SIZE=8;
  - `throughput`=1022 for the first window and 1024 for every later window.
- **Backpressure and drop:** `rate`=255, `busy`=1 held for 10 cycles → `backlog` reaches 4 (QDEPTH=4) and `dropped`=6. After `busy` falls, `data` resumes at seq 0..3, then jumps to seq 10.
- **Zero rate:** `rate`=0, `enable`=1 → `req` never asserts and `seq` is unchanged. With `rate`=64, the long-run flit count over 65536 cycles is within ±5% of 16384.
- **Drain and reset:**
  - Fill the queue to 3, drop `enable`, toggle `busy` 1/0 each cycle → 3 flits issue on alternate cycles, then `req` stays 0.
  - Assert `reset` with a full queue → no `req` after reset, `backlog`=0.
